// File: rtl/pipe_arb_pkg.sv
// Shared types and header formatting for the block-granular pipe-out arbiter.
package pipe_arb_pkg;

  localparam int CH_W   = 4;
  localparam int SEQ_W  = 12;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_XFER  = 2'd2
  } state_e;

  function automatic logic [WORD_W-1:0] pack_header(input logic [CH_W-1:0]  ch,
                                                    input logic [SEQ_W-1:0] seq);
    return {ch, seq};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request found searching from ptr+1 upward.
module rr_pick
  import pipe_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req_i,
  input  logic [CH_W-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic            valid_o
);

  localparam int IW = $clog2(N);

  // Scan N positions after the pointer; the pointer position itself is checked last.
  always_comb begin
    int idx;
    grant_o = '0;
    valid_o = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= N) begin
        idx = idx - N;
      end else begin
        idx = idx;
      end
      if (!valid_o && req_i[idx[IW-1:0]]) begin
        grant_o[idx[IW-1:0]] = 1'b1;
        valid_o              = 1'b1;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/pipe_out_arbiter.sv
// Shares one block-throttled pipe-out endpoint between N_CH FIFO sources,
// emitting a {channel, sequence} header word ahead of each block's payload.
module pipe_out_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int BLOCK_WORDS = 256,
  parameter int CNT_W       = 12
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ep_read,
  input  logic                    ep_blockstrobe,
  output logic                    ep_ready,
  output logic [15:0]             ep_datain,
  input  logic [N_CH*CNT_W-1:0]   src_count,
  input  logic [N_CH*16-1:0]      src_data,
  output logic [N_CH-1:0]         src_rd,
  input  logic [N_CH-1:0]         enable_mask,
  output logic [3:0]              active_ch,
  output logic [15:0]             blocks_sent,
  output logic                    underrun
);

  localparam int                IDX_W    = $clog2(BLOCK_WORDS);
  localparam logic [CNT_W-1:0]  THRESH   = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BLOCK_WORDS - 1);
  localparam logic [CH_W-1:0]   PTR_RST  = CH_W'(N_CH - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CH_W-1:0]        active_ch_q, active_ch_d;
  logic [CH_W-1:0]        ptr_q, ptr_d;
  logic [15:0]            blocks_q, blocks_d;
  logic                   underrun_q, underrun_d;
  logic [15:0]            datain_q, datain_d;
  logic [SEQ_W-1:0]       seq_q [N_CH];
  logic                   seq_inc_s;

  logic [N_CH-1:0]        req_s, grant_s, ch_onehot_s;
  logic                   pick_valid_s;
  logic [CH_W-1:0]        pick_ch_s;
  logic [15:0]            cur_data_s;
  logic [SEQ_W-1:0]       cur_seq_s;

  // Per-channel qualification, grant encoding and active-channel data/sequence muxes.
  always_comb begin
    req_s       = '0;
    pick_ch_s   = '0;
    ch_onehot_s = '0;
    cur_data_s  = 16'h0000;
    cur_seq_s   = '0;
    for (int c = 0; c < N_CH; c++) begin
      req_s[c] = enable_mask[c] && (src_count[c*CNT_W +: CNT_W] >= THRESH);
      if (grant_s[c]) begin
        pick_ch_s = CH_W'(c);
      end else begin
        pick_ch_s = pick_ch_s;
      end
      if (active_ch_q == CH_W'(c)) begin
        ch_onehot_s[c] = 1'b1;
        cur_data_s     = src_data[c*16 +: 16];
        cur_seq_s      = seq_q[c];
      end else begin
        ch_onehot_s[c] = 1'b0;
      end
    end
  end

  rr_pick #(.N(N_CH)) u_pick (
    .req_i   (req_s),
    .ptr_i   (ptr_q),
    .grant_o (grant_s),
    .valid_o (pick_valid_s)
  );

  // Next-state logic; FIFO pop is combinational from ep_read so the head word lands in the register.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    active_ch_d = active_ch_q;
    ptr_d       = ptr_q;
    blocks_d    = blocks_q;
    underrun_d  = underrun_q;
    datain_d    = datain_q;
    seq_inc_s   = 1'b0;
    src_rd      = '0;
    case (state_q)
      ST_IDLE: begin
        if (ep_read) begin
          underrun_d = 1'b1;
          datain_d   = 16'h0000;
        end else begin
          datain_d = datain_q;
        end
        if (pick_valid_s) begin
          active_ch_d = pick_ch_s;
          state_d     = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (ep_blockstrobe) begin
          state_d = ST_XFER;
          if (ep_read) begin
            datain_d = pack_header(active_ch_q, cur_seq_s);
            idx_d    = IDX_W'(1);
          end else begin
            idx_d = '0;
          end
        end else if (ep_read) begin
          underrun_d = 1'b1;
          datain_d   = 16'h0000;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_XFER: begin
        if (ep_read) begin
          if (idx_q == '0) begin
            datain_d = pack_header(active_ch_q, cur_seq_s);
          end else begin
            src_rd   = ch_onehot_s;
            datain_d = cur_data_s;
          end
          if (idx_q == LAST_IDX) begin
            seq_inc_s = 1'b1;
            blocks_d  = blocks_q + 16'd1;
            ptr_d     = active_ch_q;
            idx_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      active_ch_q <= '0;
      ptr_q       <= PTR_RST;
      blocks_q    <= 16'h0000;
      underrun_q  <= 1'b0;
      datain_q    <= 16'h0000;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      active_ch_q <= active_ch_d;
      ptr_q       <= ptr_d;
      blocks_q    <= blocks_d;
      underrun_q  <= underrun_d;
      datain_q    <= datain_d;
    end
  end

  // Per-channel header sequence numbers, bumped as each block completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CH; c++) seq_q[c] <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (seq_inc_s && ch_onehot_s[c]) begin
          seq_q[c] <= seq_q[c] + SEQ_W'(1);
        end else begin
          seq_q[c] <= seq_q[c];
        end
      end
    end
  end

  assign ep_ready    = (state_q == ST_ARMED);
  assign ep_datain   = datain_q;
  assign active_ch   = active_ch_q;
  assign blocks_sent = blocks_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_pipe_out_arbiter.sv
// Self-checking bench for pipe_out_arbiter: FIFO models per channel and a
// scoreboard of expected endpoint words.
module tb_pipe_out_arbiter;

  localparam int N_CH  = 4;
  localparam int BW    = 256;
  localparam int CNT_W = 12;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  ep_read = 1'b0;
  logic                  ep_blockstrobe = 1'b0;
  logic                  ep_ready;
  logic [15:0]           ep_datain;
  logic [N_CH*CNT_W-1:0] src_count;
  logic [N_CH*16-1:0]    src_data;
  logic [N_CH-1:0]       src_rd;
  logic [N_CH-1:0]       enable_mask = 4'b1111;
  logic [3:0]            active_ch;
  logic [15:0]           blocks_sent;
  logic                  underrun;

  int          cnt_lvl [N_CH] = '{default: 0};
  logic [11:0] rd_cnt  [N_CH] = '{default: 12'd0};
  logic [11:0] exp_cnt [N_CH] = '{default: 12'd0};
  logic [11:0] seq_m   [N_CH] = '{default: 12'd0};
  int          blocks_m = 0;
  logic [15:0] exp_q [$];
  int          total = 0;
  int          bad = 0;

  pipe_out_arbiter #(.N_CH(N_CH), .BLOCK_WORDS(BW), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ep_read        (ep_read),
    .ep_blockstrobe (ep_blockstrobe),
    .ep_ready       (ep_ready),
    .ep_datain      (ep_datain),
    .src_count      (src_count),
    .src_data       (src_data),
    .src_rd         (src_rd),
    .enable_mask    (enable_mask),
    .active_ch      (active_ch),
    .blocks_sent    (blocks_sent),
    .underrun       (underrun)
  );

  always #5 clk = ~clk;

  // FIFO models: head word is {channel, pop count}; a pop advances the head next cycle.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      src_count[c*CNT_W +: CNT_W] = CNT_W'(cnt_lvl[c]);
      src_data[c*16 +: 16]        = {4'(c), rd_cnt[c]};
    end
  end

  always @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (src_rd[c]) rd_cnt[c] <= rd_cnt[c] + 12'd1;
    end
  end

  task automatic set_counts(input int c0, input int c1, input int c2, input int c3);
    cnt_lvl[0] = c0; cnt_lvl[1] = c1; cnt_lvl[2] = c2; cnt_lvl[3] = c3;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0; ep_read = 1'b0; ep_blockstrobe = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < N_CH; c++) seq_m[c] = 12'd0;
    blocks_m = 0;
    exp_q.delete();
  endtask

  // Runs one block on channel ch; mask_clear_at / abort_at are word indices or -1.
  task automatic run_block(input int ch, input bit combined, input int mask_clear_at, input int abort_at);
    int          n;
    logic [N_CH-1:0] exp_rd;
    logic [15:0] want;
    logic [11:0] rd_before;
    for (n = 0; n < 100 && !ep_ready; n++) @(negedge clk);
    total++;
    if (!ep_ready) begin
      bad++; $display("FAIL arm_timeout ch=%0d ep_ready=%b want 1", ch, ep_ready);
      return;
    end
    total++;
    if (active_ch !== 4'(ch)) begin
      bad++; $display("FAIL active_ch got=%0d want=%0d", active_ch, ch);
    end
    rd_before = rd_cnt[ch];
    if (!combined) begin
      ep_blockstrobe = 1'b1;
      @(negedge clk);
      ep_blockstrobe = 1'b0;
      total++;
      if (ep_ready !== 1'b0) begin
        bad++; $display("FAIL ready_drop got=%b want=0", ep_ready);
      end
    end
    for (int i = 0; i < BW; i++) begin
      if (i == abort_at) begin
        ep_read = 1'b0;
        return;
      end
      if (i == mask_clear_at) enable_mask[ch] = 1'b0;
      if (combined && i == 0) ep_blockstrobe = 1'b1;
      ep_read = 1'b1;
      if (i == 0) begin
        exp_q.push_back({4'(ch), seq_m[ch]});
        exp_rd = '0;
      end else begin
        exp_q.push_back({4'(ch), exp_cnt[ch]});
        exp_cnt[ch] = exp_cnt[ch] + 12'd1;
        exp_rd = N_CH'(1) << ch;
      end
      #1;
      total++;
      if (src_rd !== exp_rd) begin
        bad++; $display("FAIL src_rd word=%0d got=%b want=%b", i, src_rd, exp_rd);
      end
      @(negedge clk);
      if (ep_blockstrobe) begin
        ep_blockstrobe = 1'b0;
        total++;
        if (ep_ready !== 1'b0) begin
          bad++; $display("FAIL ready_drop_comb got=%b want=0", ep_ready);
        end
      end
      want = exp_q.pop_front();
      total++;
      if (ep_datain !== want) begin
        bad++; $display("FAIL datain ch=%0d word=%0d got=%h want=%h", ch, i, ep_datain, want);
      end
    end
    ep_read = 1'b0;
    seq_m[ch] = seq_m[ch] + 12'd1;
    blocks_m++;
    total++;
    if (blocks_sent !== 16'(blocks_m)) begin
      bad++; $display("FAIL blocks_sent got=%0d want=%0d", blocks_sent, blocks_m);
    end
    total++;
    if (ep_ready !== 1'b0) begin
      bad++; $display("FAIL ready_after_block got=%b want=0", ep_ready);
    end
    total++;
    if (12'(rd_cnt[ch] - rd_before) !== 12'(BW - 1)) begin
      bad++; $display("FAIL pop_count got=%0d want=%0d", 12'(rd_cnt[ch] - rd_before), BW - 1);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    total++;
    if ({ep_ready, ep_datain, src_rd, active_ch, blocks_sent, underrun} !== '0) begin
      bad++;
      $display("FAIL reset_vals ready=%b data=%h rd=%b ch=%0d blocks=%0d underrun=%b want all 0",
               ep_ready, ep_datain, src_rd, active_ch, blocks_sent, underrun);
    end
  endtask

  task automatic test_single();
    set_counts(255, 0, 0, 0);
    enable_mask = 4'b1111;
    apply_reset();
    @(negedge clk);
    total++;
    if (ep_ready !== 1'b1) begin
      bad++; $display("FAIL single_arm_latency got=%b want=1", ep_ready);
    end
    run_block(0, 1'b0, -1, -1);
  endtask

  task automatic test_underrun();
    total++;
    if (underrun !== 1'b0) begin
      bad++; $display("FAIL underrun_pre got=%b want=0", underrun);
    end
    ep_read = 1'b1;
    #1;
    total++;
    if (src_rd !== '0) begin
      bad++; $display("FAIL underrun_rd got=%b want=0", src_rd);
    end
    @(negedge clk);
    ep_read = 1'b0;
    total++;
    if (ep_datain !== 16'h0000) begin
      bad++; $display("FAIL underrun_data got=%h want=0000", ep_datain);
    end
    repeat (5) @(negedge clk);
    total++;
    if (underrun !== 1'b1) begin
      bad++; $display("FAIL underrun_sticky got=%b want=1", underrun);
    end
    apply_reset();
    total++;
    if (underrun !== 1'b0) begin
      bad++; $display("FAIL underrun_clear got=%b want=0", underrun);
    end
  endtask

  task automatic test_fairness();
    set_counts(1000, 1000, 1000, 1000);
    enable_mask = 4'b1111;
    apply_reset();
    for (int b = 0; b < 8; b++) run_block(b % N_CH, b[0], -1, -1);
  endtask

  task automatic test_threshold();
    set_counts(0, 0, 254, 0);
    apply_reset();
    repeat (5) @(negedge clk);
    total++;
    if (ep_ready !== 1'b0) begin
      bad++; $display("FAIL thresh_below got=%b want=0", ep_ready);
    end
    cnt_lvl[2] = 255;
    @(negedge clk);
    total++;
    if (ep_ready !== 1'b1 || active_ch !== 4'd2) begin
      bad++; $display("FAIL thresh_hit ready=%b ch=%0d want 1/2", ep_ready, active_ch);
    end
  endtask

  task automatic test_mask();
    set_counts(0, 1000, 0, 0);
    enable_mask = 4'b1101;
    apply_reset();
    repeat (10) @(negedge clk);
    total++;
    if (ep_ready !== 1'b0) begin
      bad++; $display("FAIL mask_block got=%b want=0", ep_ready);
    end
    enable_mask = 4'b1111;
    run_block(1, 1'b0, 100, -1);
    repeat (5) @(negedge clk);
    total++;
    if (ep_ready !== 1'b0) begin
      bad++; $display("FAIL mask_after got=%b want=0", ep_ready);
    end
    enable_mask = 4'b1111;
  endtask

  task automatic test_reset_mid_block();
    set_counts(1000, 0, 0, 0);
    apply_reset();
    run_block(0, 1'b1, -1, -1);
    run_block(0, 1'b0, -1, 100);
    reset_n = 1'b0;
    #1;
    total++;
    if (ep_ready !== 1'b0 || ep_datain !== 16'h0000 || blocks_sent !== 16'd0 || src_rd !== '0) begin
      bad++;
      $display("FAIL midreset ready=%b data=%h blocks=%0d rd=%b want 0", ep_ready, ep_datain, blocks_sent, src_rd);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < N_CH; c++) seq_m[c] = 12'd0;
    blocks_m = 0;
    exp_q.delete();
    run_block(0, 1'b1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_underrun();
    test_fairness();
    test_threshold();
    test_mask();
    test_reset_mid_block();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_out_arbiter.md
# pipe_out_arbiter

Block-granular round-robin scheduler that shares one block-throttled pipe-out endpoint (address 0xA0 class) between N_CH FIFO-backed data sources. It sits between the host-interface pipe-out endpoint and the per-channel source FIFOs. It announces a block only when a selected channel holds a full block's payload. Every block is prefixed with a header word identifying channel and per-channel sequence number, so host software can demultiplex the stream.

## Interface
- N_CH, 4, number of source channels (2..16)
- BLOCK_WORDS, 256, 16-bit words per pipe block, header included (≥2)
- CNT_W, 12, width of each source fill count
- clk  in  1  endpoint clock (ti_clk domain); single clock
- reset_n  in  1  asynchronous, active-low reset
- ep_read  in  1  endpoint read strobe
- ep_blockstrobe  in  1  endpoint block-start strobe
- ep_ready  out  1  a full block is armed
- ep_datain  out  16  word to endpoint
- src_count  in  N_CH*CNT_W  per-channel FIFO fill levels (words)
- src_data  in  N_CH*16  per-channel FIFO outputs; read latency 1
- src_rd  out  N_CH  one-hot FIFO pop
- enable_mask  in  N_CH  channel enables (host wire)
- active_ch  out  4  channel owning the current/armed block
- blocks_sent  out  16  total completed blocks, wraps
- underrun  out  1  sticky: ep_read outside a block

## Operation
- States: IDLE, ARMED, XFER.
- IDLE: round-robin search starting at ptr+1 (mod N_CH) for first channel with enable_mask set and src_count ≥ BLOCK_WORDS−1. On hit: latch ch into active_ch, go ARMED. No hit: stay.
- ARMED: ep_ready=1. On ep_blockstrobe: go XFER, word index=0. enable_mask or count changes in ARMED do not cancel the arm.
- XFER: each ep_read increments word index.
  - index 0 read: no src_rd; next cycle ep_datain = header {ch[3:0], seq[ch][11:0]}.
  - index 1..BLOCK_WORDS−1 read: src_rd[ch]=1 same cycle (combinational from ep_read); next cycle ep_datain = src_data[ch].
  - On read of index BLOCK_WORDS−1: seq[ch] += 1 (wraps 4095→0), blocks_sent += 1, ptr=ch, go IDLE.
- ep_blockstrobe and ep_read same cycle in ARMED: block start plus index-0 read.
- ep_read in IDLE or ARMED (without strobe): no pop, ep_datain = 0x0000 next cycle, underrun set (cleared only by reset).
- ep_blockstrobe in IDLE or XFER: ignored.
- Disabling a channel mid-block: block still completes.

## Timing
- Reset values: ep_ready=0, ep_datain=0x0000, src_rd=0, active_ch=0, blocks_sent=0, underrun=0; all seq=0; ptr=N_CH−1 so channel 0 wins first; state IDLE.
- Selection: qualifying count sampled in IDLE → ep_ready high next cycle.
- ep_ready drops the cycle after ep_blockstrobe.
- ep_datain is registered, valid exactly one cycle after the ep_read that requested it, and held until the next read.
- src_rd never asserts for more than one channel, never outside XFER.
- Reset asserted mid-block: immediate return to reset values; the partial block is abandoned (host restarts via pipe reset).
- After block end, IDLE re-arms no sooner than 1 cycle later; back-to-back blocks lose one cycle of ep_ready.

## Structure
- Package pipe_arb_pkg: state enum, header field widths (CH_W=4, SEQ_W=12), header pack function.
- Sub-module rr_pick: combinational round-robin picker (request vector, pointer → one-hot grant, valid).
- Top holds FSM, word index counter, seq array, output register.

## Test plan
- Single channel: ch0 count=255, others 0, BLOCK_WORDS=256 → ep_ready 1 cycle later; 256 reads return 0x0000 header, then 255 FIFO words in order; 255 src_rd[0] pulses; blocks_sent=1.
- Fairness: all four channels count=1000, run 8 blocks → header channel order 0,1,2,3,0,1,2,3; second-round headers carry seq=1.
- Threshold: ch2 count=254 → ep_ready stays 0; step to 255 → ep_ready next cycle, active_ch=2.
- Mask: ch1 full but enable_mask[1]=0 → never selected; clear mask during ch1's XFER → block completes, 256 words.
- Underrun: ep_read in IDLE → ep_datain=0x0000, no src_rd, underrun=1 persists until reset.
- Reset mid-block: drop reset_n at word 100 → ep_ready=0, seq cleared; after release, next ch0 block header = 0x0000.
